spi_fifo_transceiver: RTL and testbench
=======================================

Name: spi_fifo_transceiver

Overview:
- Parametrised full-duplex SPI master. Supersedes the separate single-register sender and receiver pair.
- Contains a TX FIFO and an RX FIFO, a clock divider, and a transfer state machine.
- Generates SCLK and SS_N, supports all four CPOL/CPHA modes, and supports MSB- or LSB-first order.
- Sits between a host register interface (WRITE/READ strobes) and the SPI pins. Back-to-back words stream with SS_N held low.

Parameters:
- DATA_W, 8: word width in bits, >=2.
- DEPTH, 4: entries per FIFO, power of two, >=2.
- CLK_DIV, 2: CLK cycles per SCLK half-period, >=1.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.
- LSB_FIRST, 0: 1 = shift LSB first.

Ports:
- CLK, input, 1: the single clock; all logic is on the rising edge.
- CLR, input, 1: synchronous active-high reset.
- DATA_IN, input, DATA_W: word to push into the TX FIFO.
- WRITE, input, 1: push DATA_IN into the TX FIFO.
- READ, input, 1: pop the RX FIFO head.
- TE, input, 1: transmit enable; permits starting new transfers.
- RE, input, 1: receive enable; received words are stored only while RE=1.
- MISO, input, 1: serial data in.
- MOSI, output, 1: serial data out (registered).
- SCLK, output, 1: serial clock (registered).
- SS_N, output, 1: slave select, active low (registered).
- DATA_OUT, output, DATA_W: RX FIFO head (show-ahead).
- TX_FULL, output, 1: TX FIFO full.
- TX_EMPTY, output, 1: TX FIFO empty.
- RX_FULL, output, 1: RX FIFO full.
- RX_EMPTY, output, 1: RX FIFO empty.
- BUSY, output, 1: high whenever the state is not IDLE.
- RX_OVF, output, 1: sticky flag; a received word was dropped because the RX FIFO was full.

Behaviour:
- Clock and reset: one clock, CLK. CLR is synchronous and active-high, and has priority over every other input.
- Reset values:
  - MOSI=0, SCLK=CPOL, SS_N=1, BUSY=0, RX_OVF=0.
  - TX_EMPTY=1, RX_EMPTY=1, TX_FULL=0, RX_FULL=0, DATA_OUT=0.
  - Both FIFOs empty, state IDLE.
- FIFOs: DEPTH entries each, with pointers wrapping modulo DEPTH and an occupancy counter of width clog2(DEPTH)+1. Flags are registered and update the cycle after the event.
- TX FIFO write rules:
  - WRITE while TX_FULL is ignored, even if the FSM pops in the same cycle.
  - WRITE and pop in the same cycle when not full: both take effect; the count is unchanged.
- RX FIFO read rules:
  - READ while RX_EMPTY is ignored.
  - DATA_OUT is the head word while RX_EMPTY=0, and is forced to 0 while RX_EMPTY=1.
  - An internal push while RX_FULL coincident with READ is accepted; the count stays at DEPTH and RX_OVF is not set.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - SS_N=1, SCLK=CPOL.
  - If TE=1 and TX_EMPTY=0: pop the TX head into the shift register; next cycle SS_N=0, state SHIFT.
  - If CPHA=0, MOSI takes the first bit in the same cycle SS_N falls.
- SHIFT:
  - The divider counts 0..CLK_DIV-1; on wrap, SCLK toggles and the edge counter increments.
  - Leading edge = odd-numbered edge; trailing edge = even-numbered edge.
  - Sample and shift follow CPHA.
  - For CPHA=1, the first bit is driven on edge 1.
  - After edge 2*DATA_W, go to DONE. SHIFT lasts exactly 2*DATA_W*CLK_DIV cycles.
- DONE (one cycle):
  - If RE=1: push the assembled word to the RX FIFO. If RX is full without a coincident READ, drop the word and set RX_OVF=1.
  - If RE=0: discard the word, no flag change.
  - Then, if TE=1 and TX_EMPTY=0: pop the next word and return to SHIFT with SS_N held low. No SS_N gap; exactly one idle CPOL-level period between words.
  - Otherwise: SS_N=1 next cycle, state IDLE.
- TE deasserted mid-word: the current word completes; no new word starts.
- RE changes mid-word: only the RE value in the DONE cycle matters.
- RX timing: RX_EMPTY falls 2*DATA_W*CLK_DIV+2 cycles after the cycle in which SS_N first reads 0, when the FIFO was previously empty.
- RX_OVF clears only on CLR.
- CLR mid-transfer: abort; all outputs take their reset values on the next edge; no partial word is pushed.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined:
  - Adds input port LOOP (1 bit).
  - While LOOP=1, the sampler uses the internal MOSI register instead of the MISO pin; the MOSI/SCLK/SS_N pins still toggle normally.
  - LOOP is sampled only in IDLE, so a change mid-transfer takes effect on the next word.
- Undefined: no LOOP port; MISO is always sampled.

Test Plan:
- Config: DATA_W=8, CLK_DIV=2, mode 0, MISO tied to MOSI. CLR, WRITE 8'h62, TE=RE=1.
  -> SS_N low for 33 cycles, 16 SCLK edges, MOSI bit sequence 0,1,1,0,0,0,1,0.
  -> RX_EMPTY=0 and DATA_OUT=8'h62; READ -> RX_EMPTY=1, DATA_OUT=0.
- WRITE 8'hA5, 8'h3C, 8'hFF, 8'h01, then a 5th WRITE 8'h77.
  -> TX_FULL=1 after the 4th write; 5th ignored.
  -> TE=1 streams 4 words with SS_N never high between them; RX holds A5, 3C, FF, 01 in order.
- RE=0, TE=1, one word sent -> RX_EMPTY stays 1, RX_OVF=0. READ then leaves DATA_OUT=0.
- RX full with 4 words, 5th transfer with RE=1 and no READ -> RX_OVF=1, RX contents unchanged. CLR -> RX_OVF=0.
- CLR asserted on SCLK edge 7 of a transfer -> next cycle SS_N=1, SCLK=CPOL, BUSY=0, RX_EMPTY=1.
- Sweep all 4 CPOL/CPHA combinations with LSB_FIRST=1, word 8'h81, loopback -> DATA_OUT=8'h81. SCLK idle level equals CPOL before and after the transfer.

Source files
------------

// File: rtl/spi_fifo_transceiver.sv
// Full-duplex SPI master: TX/RX FIFOs, SCLK divider and IDLE/SHIFT/DONE transfer FSM.
// Optional macro SPI_LOOPBACK_EN adds a LOOP input that feeds the MOSI register back into the sampler.
module spi_fifo_transceiver #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int CLK_DIV   = 2,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int LSB_FIRST = 0
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              WRITE,
  input  logic              READ,
  input  logic              TE,
  input  logic              RE,
`ifdef SPI_LOOPBACK_EN
  input  logic              LOOP,
`endif
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCLK,
  output logic              SS_N,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              TX_FULL,
  output logic              TX_EMPTY,
  output logic              RX_FULL,
  output logic              RX_EMPTY,
  output logic              BUSY,
  output logic              RX_OVF
);

  localparam int   PW       = $clog2(DEPTH);
  localparam int   CW       = $clog2(DEPTH) + 1;
  localparam int   DVW      = $clog2(CLK_DIV + 1);
  localparam int   EW       = $clog2(2 * DATA_W + 1);
  localparam logic IDLE_LVL = (CPOL != 0);
  localparam logic CPHA_L   = (CPHA != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    if (LSB_FIRST != 0) head_bit = w[0];
    else                head_bit = w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] w);
    if (LSB_FIRST != 0) drop_bit = {1'b0, w[DATA_W-1:1]};
    else                drop_bit = {w[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] add_bit(input logic [DATA_W-1:0] w, input logic b);
    if (LSB_FIRST != 0) add_bit = {b, w[DATA_W-1:1]};
    else                add_bit = {w[DATA_W-2:0], b};
  endfunction

  state_t            state_r, state_s;
  logic [DVW-1:0]    div_r, div_s;
  logic [EW-1:0]     edge_r, edge_s, edge_num_s;
  logic              sclk_r, sclk_s, ss_n_r, ss_n_s, mosi_r, mosi_s, busy_r, ovf_r;
  logic [DATA_W-1:0] tx_sh_r, tx_sh_s, rx_sh_r, rx_sh_s, rx_word_r, rx_word_s, tx_head_s;
  logic              rx_push_r, rx_push_s, tx_pop_s, start_s;
  logic              wrap_s, leading_s, last_s, sample_s, sample_bit_s;

  logic [DATA_W-1:0] tx_mem_r [DEPTH];
  logic [DATA_W-1:0] rx_mem_r [DEPTH];
  logic [PW-1:0]     tx_wr_ptr_r, tx_rd_ptr_r, rx_wr_ptr_r, rx_rd_ptr_r;
  logic [CW-1:0]     tx_cnt_r, tx_cnt_s, rx_cnt_r, rx_cnt_s;
  logic              tx_full_r, tx_empty_r, rx_full_r, rx_empty_r;
  logic              tx_push_s, rx_rd_s, rx_wr_s, rx_drop_s;

  assign edge_num_s = edge_r + EW'(1);
  assign wrap_s     = (div_r == DVW'(CLK_DIV - 1));
  assign leading_s  = edge_num_s[0];
  assign last_s     = (edge_num_s == EW'(2 * DATA_W));
  assign sample_s   = leading_s ^ CPHA_L;
  assign tx_head_s  = tx_mem_r[tx_rd_ptr_r];

  // A full TX FIFO rejects writes even when the FSM pops in the same cycle.
  assign tx_push_s = WRITE & ~tx_full_r;
  assign rx_rd_s   = READ & ~rx_empty_r;
  assign rx_wr_s   = rx_push_r & (~rx_full_r | rx_rd_s);
  assign rx_drop_s = rx_push_r & rx_full_r & ~rx_rd_s;

`ifdef SPI_LOOPBACK_EN
  logic loop_r;
  // LOOP is only latched while idle so a word never switches source mid-shift.
  always_ff @(posedge CLK) begin
    if (CLR)                  loop_r <= 1'b0;
    else if (state_r == IDLE) loop_r <= LOOP;
    else                      loop_r <= loop_r;
  end
  assign sample_bit_s = loop_r ? mosi_r : MISO;
`else
  assign sample_bit_s = MISO;
`endif

  // Transfer FSM next-state, divider, edge counter and shift datapath.
  always_comb begin
    state_s   = state_r;
    div_s     = div_r;
    edge_s    = edge_r;
    sclk_s    = sclk_r;
    ss_n_s    = ss_n_r;
    mosi_s    = mosi_r;
    tx_sh_s   = tx_sh_r;
    rx_sh_s   = rx_sh_r;
    rx_word_s = rx_word_r;
    rx_push_s = 1'b0;
    start_s   = 1'b0;
    tx_pop_s  = 1'b0;
    case (state_r)
      IDLE: begin
        ss_n_s  = 1'b1;
        sclk_s  = IDLE_LVL;
        start_s = TE & ~tx_empty_r;
      end
      SHIFT: begin
        if (wrap_s) begin
          div_s  = '0;
          edge_s = edge_num_s;
          sclk_s = ~sclk_r;
          if (sample_s) begin
            rx_sh_s = add_bit(rx_sh_r, sample_bit_s);
          end else if (!last_s) begin
            mosi_s  = head_bit(tx_sh_r);
            tx_sh_s = drop_bit(tx_sh_r);
          end else begin
            mosi_s = mosi_r;
          end
          if (last_s) state_s = DONE;
          else        state_s = SHIFT;
        end else begin
          div_s = div_r + DVW'(1);
        end
      end
      DONE: begin
        rx_push_s = RE;
        rx_word_s = rx_sh_r;
        start_s   = TE & ~tx_empty_r;
        if (start_s) begin
          ss_n_s = 1'b0;
        end else begin
          ss_n_s  = 1'b1;
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    // Starting a word: CPHA=0 presents the first bit together with the SS_N fall.
    if (start_s) begin
      tx_pop_s = 1'b1;
      state_s  = SHIFT;
      ss_n_s   = 1'b0;
      div_s    = '0;
      edge_s   = '0;
      sclk_s   = IDLE_LVL;
      rx_sh_s  = '0;
      if (!CPHA_L) begin
        mosi_s  = head_bit(tx_head_s);
        tx_sh_s = drop_bit(tx_head_s);
      end else begin
        tx_sh_s = tx_head_s;
      end
    end else begin
      tx_pop_s = 1'b0;
    end
  end

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    tx_cnt_s = tx_cnt_r;
    rx_cnt_s = rx_cnt_r;
    if (tx_push_s && !tx_pop_s)      tx_cnt_s = tx_cnt_r + CW'(1);
    else if (!tx_push_s && tx_pop_s) tx_cnt_s = tx_cnt_r - CW'(1);
    else                             tx_cnt_s = tx_cnt_r;
    if (rx_wr_s && !rx_rd_s)         rx_cnt_s = rx_cnt_r + CW'(1);
    else if (!rx_wr_s && rx_rd_s)    rx_cnt_s = rx_cnt_r - CW'(1);
    else                             rx_cnt_s = rx_cnt_r;
  end

  // FSM and serial-pin registers.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_r   <= IDLE;
      div_r     <= '0;
      edge_r    <= '0;
      sclk_r    <= IDLE_LVL;
      ss_n_r    <= 1'b1;
      mosi_r    <= 1'b0;
      tx_sh_r   <= '0;
      rx_sh_r   <= '0;
      rx_word_r <= '0;
      rx_push_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      div_r     <= div_s;
      edge_r    <= edge_s;
      sclk_r    <= sclk_s;
      ss_n_r    <= ss_n_s;
      mosi_r    <= mosi_s;
      tx_sh_r   <= tx_sh_s;
      rx_sh_r   <= rx_sh_s;
      rx_word_r <= rx_word_s;
      rx_push_r <= rx_push_s;
      busy_r    <= (state_s != IDLE);
    end
  end

  // FIFO pointers, counters, registered flags and the sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      tx_wr_ptr_r <= '0;
      tx_rd_ptr_r <= '0;
      rx_wr_ptr_r <= '0;
      rx_rd_ptr_r <= '0;
      tx_cnt_r    <= '0;
      rx_cnt_r    <= '0;
      tx_full_r   <= 1'b0;
      tx_empty_r  <= 1'b1;
      rx_full_r   <= 1'b0;
      rx_empty_r  <= 1'b1;
      ovf_r       <= 1'b0;
    end else begin
      if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + PW'(1);
      if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + PW'(1);
      if (rx_wr_s)   rx_wr_ptr_r <= rx_wr_ptr_r + PW'(1);
      if (rx_rd_s)   rx_rd_ptr_r <= rx_rd_ptr_r + PW'(1);
      tx_cnt_r   <= tx_cnt_s;
      rx_cnt_r   <= rx_cnt_s;
      tx_full_r  <= (tx_cnt_s == CW'(DEPTH));
      tx_empty_r <= (tx_cnt_s == CW'(0));
      rx_full_r  <= (rx_cnt_s == CW'(DEPTH));
      rx_empty_r <= (rx_cnt_s == CW'(0));
      ovf_r      <= ovf_r | rx_drop_s;
    end
  end

  // FIFO storage; contents need no reset because the flags gate every read.
  always_ff @(posedge CLK) begin
    if (!CLR && tx_push_s) tx_mem_r[tx_wr_ptr_r] <= DATA_IN;
    if (!CLR && rx_wr_s)   rx_mem_r[rx_wr_ptr_r] <= rx_word_r;
  end

  assign MOSI     = mosi_r;
  assign SCLK     = sclk_r;
  assign SS_N     = ss_n_r;
  assign BUSY     = busy_r;
  assign RX_OVF   = ovf_r;
  assign TX_FULL  = tx_full_r;
  assign TX_EMPTY = tx_empty_r;
  assign RX_FULL  = rx_full_r;
  assign RX_EMPTY = rx_empty_r;
  assign DATA_OUT = rx_empty_r ? '0 : rx_mem_r[rx_rd_ptr_r];

endmodule

// File: tb/tb_spi_fifo_transceiver.sv
// Bench for spi_fifo_transceiver: mode-0 loopback DUT plus four LSB-first loopback DUTs, one per CPOL/CPHA.
module tb_spi_fifo_transceiver;

  logic       clk = 1'b0;
  logic       clr, wr, rd, te, re, sw_wr, sw_rd;
  logic [7:0] din, sw_din, dout;
  logic       mosi, sclk, ss_n, tx_full, tx_empty, rx_full, rx_empty, busy, rx_ovf;
  logic [3:0] sw_mosi, sw_sclk, sw_ssn, sw_txf, sw_txe, sw_rxf, sw_rxe, sw_busy, sw_ovf;
  logic [7:0] sw_dout [4];

  int errors = 0;
  int checks = 0;
  logic [7:0] sb [$];

  typedef struct {
    logic [7:0] din;
    logic [7:0] mosi_exp;
    logic [7:0] rx_exp;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  spi_fifo_transceiver #(.DATA_W(8), .DEPTH(4), .CLK_DIV(2), .CPOL(0), .CPHA(0), .LSB_FIRST(0)) dut (
    .CLK(clk), .CLR(clr), .DATA_IN(din), .WRITE(wr), .READ(rd), .TE(te), .RE(re),
`ifdef SPI_LOOPBACK_EN
    .LOOP(1'b0),
`endif
    .MISO(mosi), .MOSI(mosi), .SCLK(sclk), .SS_N(ss_n), .DATA_OUT(dout),
    .TX_FULL(tx_full), .TX_EMPTY(tx_empty), .RX_FULL(rx_full), .RX_EMPTY(rx_empty),
    .BUSY(busy), .RX_OVF(rx_ovf)
  );

  for (genvar m = 0; m < 4; m++) begin : g_sw
    spi_fifo_transceiver #(.DATA_W(8), .DEPTH(4), .CLK_DIV(2), .CPOL(m / 2), .CPHA(m % 2), .LSB_FIRST(1)) u_sw (
      .CLK(clk), .CLR(clr), .DATA_IN(sw_din), .WRITE(sw_wr), .READ(sw_rd), .TE(1'b1), .RE(1'b1),
`ifdef SPI_LOOPBACK_EN
      .LOOP(1'b0),
`endif
      .MISO(sw_mosi[m]), .MOSI(sw_mosi[m]), .SCLK(sw_sclk[m]), .SS_N(sw_ssn[m]), .DATA_OUT(sw_dout[m]),
      .TX_FULL(sw_txf[m]), .TX_EMPTY(sw_txe[m]), .RX_FULL(sw_rxf[m]), .RX_EMPTY(sw_rxe[m]),
      .BUSY(sw_busy[m]), .RX_OVF(sw_ovf[m])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [7:0] w);
    din = w;
    wr  = 1'b1;
    @(negedge clk);
    wr  = 1'b0;
  endtask

  // Runs until the DUT has been idle with an empty TX FIFO for 4 cycles, bounded.
  task automatic wait_quiet(input string tag);
    int q;
    int c;
    q = 0;
    c = 0;
    while (q < 4 && c < 1000) begin
      @(negedge clk);
      c++;
      if (!busy && tx_empty) q++;
      else q = 0;
    end
    check({tag, " settle"}, 32'(q >= 4), 32'd1);
  endtask

  task automatic drain(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      if (sb.size() == 0) begin
        check({tag, " scoreboard underflow"}, 32'd0, 32'd1);
      end else begin
        check({tag, " data_out"}, 32'(dout), 32'(sb.pop_front()));
      end
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
    end
  endtask

  // Single word on the main DUT: frame length, edge count, MOSI bits and RX latency.
  task automatic watch_word(input logic [7:0] mosi_exp);
    int ssn_low, edges, first_low, rx_at;
    logic [7:0] bits;
    logic prev;
    ssn_low = 0; edges = 0; first_low = -1; rx_at = -1; bits = 8'h00; prev = sclk;
    for (int c = 0; c < 200 && rx_at < 0; c++) begin
      @(negedge clk);
      if (!ss_n) begin
        ssn_low++;
        if (first_low < 0) first_low = c;
      end
      if (sclk !== prev) begin
        edges++;
        if (sclk) bits = {bits[6:0], mosi};
      end
      prev = sclk;
      if (!rx_empty) rx_at = c;
    end
    check("ss_n low cycles", 32'(ssn_low), 32'd33);
    check("sclk edges", 32'(edges), 32'd16);
    check("mosi bits", 32'(bits), 32'(mosi_exp));
    check("rx_empty latency", 32'(rx_at - first_low), 32'd34);
  endtask

  // One word through all four sweep DUTs, capturing MOSI on each mode's sampling edge.
  task automatic sweep_word(input logic [7:0] w);
    logic [7:0] cap [4];
    int edg [4];
    logic [3:0] prev;
    logic [7:0] c8;
    for (int m = 0; m < 4; m++) begin
      cap[m] = 8'h00;
      edg[m] = 0;
    end
    sw_din = w;
    sw_wr  = 1'b1;
    @(negedge clk);
    sw_wr  = 1'b0;
    prev   = sw_sclk;
    for (int c = 0; c < 300 && sw_rxe != 4'b0000; c++) begin
      @(negedge clk);
      for (int m = 0; m < 4; m++) begin
        if (sw_sclk[m] !== prev[m]) begin
          edg[m]++;
          if ((edg[m] % 2) == ((m % 2 == 0) ? 1 : 0)) begin
            c8 = cap[m];
            cap[m] = {sw_mosi[m], c8[7:1]};
          end
        end
      end
      prev = sw_sclk;
    end
    for (int m = 0; m < 4; m++) begin
      check($sformatf("sweep mode%0d data_out", m), 32'(sw_dout[m]), 32'(w));
      check($sformatf("sweep mode%0d mosi order", m), 32'(cap[m]), 32'(w));
      check($sformatf("sweep mode%0d sclk edges", m), 32'(edg[m]), 32'd16);
    end
    check("sweep sclk idle after", 32'(sw_sclk), 32'(4'b1100));
    sw_rd = 1'b1;
    @(negedge clk);
    sw_rd = 1'b0;
    check("sweep rx_empty after read", 32'(sw_rxe), 32'(4'b1111));
  endtask

  initial begin
    int edges;
    int rises;
    logic prev_sclk, prev_ssn;

    vecs[0] = '{din: 8'h62, mosi_exp: 8'b0110_0010, rx_exp: 8'h62};
    vecs[1] = '{din: 8'hA5, mosi_exp: 8'b1010_0101, rx_exp: 8'hA5};
    vecs[2] = '{din: 8'h00, mosi_exp: 8'b0000_0000, rx_exp: 8'h00};
    vecs[3] = '{din: 8'hFF, mosi_exp: 8'b1111_1111, rx_exp: 8'hFF};

    clr = 1'b1; wr = 1'b0; rd = 1'b0; te = 1'b0; re = 1'b0; din = 8'h00;
    sw_wr = 1'b0; sw_rd = 1'b0; sw_din = 8'h00;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    check("reset mosi", 32'(mosi), 32'd0);
    check("reset sclk", 32'(sclk), 32'd0);
    check("reset ss_n", 32'(ss_n), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rx_ovf", 32'(rx_ovf), 32'd0);
    check("reset tx_empty", 32'(tx_empty), 32'd1);
    check("reset rx_empty", 32'(rx_empty), 32'd1);
    check("reset tx_full", 32'(tx_full), 32'd0);
    check("reset rx_full", 32'(rx_full), 32'd0);
    check("reset data_out", 32'(dout), 32'd0);
    check("sweep sclk idle before", 32'(sw_sclk), 32'(4'b1100));
    check("sweep ss_n idle", 32'(sw_ssn), 32'(4'b1111));

    te = 1'b1; re = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(vecs[i].rx_exp);
      write_word(vecs[i].din);
      watch_word(vecs[i].mosi_exp);
      drain(1, "single");
      check("rx_empty after read", 32'(rx_empty), 32'd1);
      check("data_out after read", 32'(dout), 32'd0);
    end

    // Fill TX with TE low, overflow it by one write, then stream.
    te = 1'b0;
    din = 8'hA5; wr = 1'b1; sb.push_back(8'hA5); @(negedge clk);
    din = 8'h3C; sb.push_back(8'h3C); @(negedge clk);
    din = 8'hFF; sb.push_back(8'hFF); @(negedge clk);
    din = 8'h01; sb.push_back(8'h01); @(negedge clk);
    check("tx_full after 4 writes", 32'(tx_full), 32'd1);
    din = 8'h77; @(negedge clk);
    wr = 1'b0;
    check("tx_full after ignored write", 32'(tx_full), 32'd1);
    te = 1'b1;
    edges = 0; rises = 0; prev_sclk = sclk; prev_ssn = ss_n;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (sclk !== prev_sclk) edges++;
      if (ss_n && !prev_ssn) rises++;
      prev_sclk = sclk;
      prev_ssn  = ss_n;
      if (c > 140 && !busy && !rx_empty && tx_empty && rx_full) break;
    end
    te = 1'b0;
    repeat (3) @(negedge clk);
    check("stream sclk edges", 32'(edges), 32'd64);
    check("stream ss_n rises", 32'(rises), 32'd1);
    check("stream tx_empty", 32'(tx_empty), 32'd1);
    check("stream rx_full", 32'(rx_full), 32'd1);
    check("stream rx_ovf", 32'(rx_ovf), 32'd0);
    drain(4, "stream");
    check("stream rx_empty drained", 32'(rx_empty), 32'd1);

    // RE low: the word is discarded without touching the overflow flag.
    te = 1'b1; re = 1'b0;
    write_word(8'h55);
    wait_quiet("re0");
    check("re0 rx_empty", 32'(rx_empty), 32'd1);
    check("re0 rx_ovf", 32'(rx_ovf), 32'd0);
    rd = 1'b1; @(negedge clk); rd = 1'b0;
    check("re0 data_out after read", 32'(dout), 32'd0);
    re = 1'b1;

    // Overflow: fill RX, send one more without reading.
    din = 8'h11; wr = 1'b1; sb.push_back(8'h11); @(negedge clk);
    din = 8'h22; sb.push_back(8'h22); @(negedge clk);
    din = 8'h33; sb.push_back(8'h33); @(negedge clk);
    din = 8'h44; sb.push_back(8'h44); @(negedge clk);
    wr = 1'b0;
    wait_quiet("fill");
    check("fill rx_full", 32'(rx_full), 32'd1);
    check("fill rx_ovf", 32'(rx_ovf), 32'd0);
    write_word(8'h99);
    wait_quiet("ovf");
    check("ovf rx_ovf", 32'(rx_ovf), 32'd1);
    check("ovf rx_full", 32'(rx_full), 32'd1);
    drain(4, "ovf");
    check("ovf sticky after drain", 32'(rx_ovf), 32'd1);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    check("ovf cleared by clr", 32'(rx_ovf), 32'd0);

    // CLR on SCLK edge 7 aborts the word.
    write_word(8'hC3);
    edges = 0; prev_sclk = sclk;
    for (int c = 0; c < 200 && edges < 7; c++) begin
      @(negedge clk);
      if (sclk !== prev_sclk) edges++;
      prev_sclk = sclk;
    end
    check("abort reached edge 7", 32'(edges), 32'd7);
    clr = 1'b1; @(negedge clk); clr = 1'b0; te = 1'b0;
    check("abort ss_n", 32'(ss_n), 32'd1);
    check("abort sclk", 32'(sclk), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort rx_empty", 32'(rx_empty), 32'd1);
    check("abort mosi", 32'(mosi), 32'd0);
    repeat (60) @(negedge clk);
    check("abort no partial push", 32'(rx_empty), 32'd1);

    sweep_word(8'h81);
    sweep_word(8'h4D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
